chan_sel_scheduler: RTL and testbench

- Time-multiplexes the channel-select datapath across up to four software-programmed channel bins (ch_bin0..3).
- Dwells on each bin for a programmed number of readout frames, then advances to the next bin.
- All switches are aligned to the frame boundary, so the selected-channel stream never changes mid-frame.
- Sits in the user_clk domain, between the ppc2simulink channel-bin and control registers and the channel-select mux feeding the capture logic.

---
 rtl/chan_sel_scheduler.sv | 161 ++++++++++++++++
 tb/tb_chan_sel_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_sel_scheduler.sv
// Frame-aligned channel-bin scheduler: dwells N frames per slot, then steps to the next bin.
// Latency: frame_sync to ch_sel/switch_pulse update is exactly 1 cycle.
// No backpressure: frame_sync is a free-running strobe; run=0 stops the sequence on the next edge.
module chan_sel_scheduler #(
  parameter int CH_W    = 9,
  parameter int DWELL_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_reg,
  input  logic [31:0]       ch_bin0,
  input  logic [31:0]       ch_bin1,
  input  logic [31:0]       ch_bin2,
  input  logic [31:0]       ch_bin3,
  input  logic              frame_sync,
  output logic [CH_W-1:0]   ch_sel,
  output logic              ch_sel_valid,
  output logic [1:0]        slot_idx,
  output logic              switch_pulse,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic                 run_d;
  // After reset run must be seen low once before a rising edge counts as a start,
  // so a run bit left high across reset does not restart the sequence.
  logic                 armed;
  logic [1:0]           last_slot_q;
  logic                 one_shot_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt;

  logic                 run;
  logic                 start;
  logic [DWELL_W-1:0]   dwell_in;
  logic [DWELL_W-1:0]   dwell_eff;
  logic                 do_load;
  logic                 do_finish;
  logic [1:0]           load_slot;
  logic [31:0]          load_bin;

  assign run       = ctrl_reg[0];
  assign start     = run & ~run_d & armed;
  assign dwell_in  = DWELL_W'(ctrl_reg[31:16]);
  assign dwell_eff = (dwell_in == '0) ? DWELL_W'(1) : dwell_in;

  // Upper bin bits and reserved control bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{ctrl_reg[15:4], ch_bin0[31:CH_W], ch_bin1[31:CH_W],
                         ch_bin2[31:CH_W], ch_bin3[31:CH_W]};

  // Decide whether this frame_sync loads a slot (and which) or ends a one-shot run.
  always_comb begin
    do_load   = 1'b0;
    do_finish = 1'b0;
    load_slot = 2'd0;
    if (run && frame_sync) begin
      if (state == ARM) begin
        do_load   = 1'b1;
        load_slot = 2'd0;
      end else if (state == DWELL && cnt == '0) begin
        if (slot_idx != last_slot_q) begin
          do_load   = 1'b1;
          load_slot = slot_idx + 2'd1;
        end else if (!one_shot_q) begin
          do_load   = 1'b1;
          load_slot = 2'd0;
        end else begin
          do_finish = 1'b1;
        end
      end
    end
  end

  // Bin sampled at load time so software can retune slots that are not on air.
  always_comb begin
    load_bin = ch_bin0;
    case (load_slot)
      2'd0: load_bin = ch_bin0;
      2'd1: load_bin = ch_bin1;
      2'd2: load_bin = ch_bin2;
      2'd3: load_bin = ch_bin3;
      default: load_bin = ch_bin0;
    endcase
  end

  // Scheduler FSM with registered outputs; stop (run=0) overrides everything.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state        <= IDLE;
      run_d        <= 1'b0;
      armed        <= 1'b0;
      last_slot_q  <= 2'd0;
      one_shot_q   <= 1'b0;
      dwell_q      <= '0;
      cnt          <= '0;
      ch_sel       <= '0;
      ch_sel_valid <= 1'b0;
      slot_idx     <= 2'd0;
      switch_pulse <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      run_d        <= run;
      switch_pulse <= 1'b0;
      if (!run) begin
        armed <= 1'b1;
      end

      if (!run) begin
        state        <= IDLE;
        ch_sel_valid <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // frame_sync coincident with the start is not a load opportunity.
            if (start) begin
              last_slot_q <= ctrl_reg[3:2];
              one_shot_q  <= ctrl_reg[1];
              dwell_q     <= dwell_eff;
              busy        <= 1'b1;
              state       <= ARM;
            end
          end
          ARM, DWELL: begin
            if (do_load) begin
              ch_sel       <= load_bin[CH_W-1:0];
              slot_idx     <= load_slot;
              ch_sel_valid <= 1'b1;
              switch_pulse <= 1'b1;
              cnt          <= dwell_q - DWELL_W'(1);
              state        <= DWELL;
            end else if (do_finish) begin
              ch_sel_valid <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else if (state == DWELL && frame_sync && cnt != '0) begin
              cnt <= cnt - DWELL_W'(1);
            end
          end
          DONE: begin
            // Hold results until software drops run.
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chan_sel_scheduler.sv
// Randomised and directed bench for chan_sel_scheduler against a frame-count reference model.
// Expected outputs derive from frame index arithmetic: slot = (j / dwell) % (last+1).
// Outputs sampled 1 time unit after each rising edge; inputs change there too.
module tb_chan_sel_scheduler;

  logic        user_clk = 1'b0;
  logic        user_rst_n = 1'b0;
  logic [31:0] ctrl_reg = '0;
  logic [31:0] ch_bin0 = '0, ch_bin1 = '0, ch_bin2 = '0, ch_bin3 = '0;
  logic        frame_sync = 1'b0;
  logic [8:0]  ch_sel;
  logic        ch_sel_valid;
  logic [1:0]  slot_idx;
  logic        switch_pulse;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  chan_sel_scheduler #(.CH_W(9), .DWELL_W(16)) dut (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .ctrl_reg     (ctrl_reg),
    .ch_bin0      (ch_bin0),
    .ch_bin1      (ch_bin1),
    .ch_bin2      (ch_bin2),
    .ch_bin3      (ch_bin3),
    .frame_sync   (frame_sync),
    .ch_sel       (ch_sel),
    .ch_sel_valid (ch_sel_valid),
    .slot_idx     (slot_idx),
    .switch_pulse (switch_pulse),
    .busy         (busy),
    .done         (done)
  );

  always #5 user_clk = ~user_clk;

  // Reference model: counts frames since start, derives the slot arithmetically.
  bit   m_active, m_done, m_armed, m_run_prev, m_one;
  int   m_frames, m_last, m_dwell;
  logic [8:0] e_sel;
  logic [1:0] e_slot;
  logic e_vld, e_pulse, e_busy, e_done;

  function automatic logic [14:0] obs();
    return {ch_sel, ch_sel_valid, slot_idx, switch_pulse, busy, done};
  endfunction

  function automatic logic [14:0] expv();
    return {e_sel, e_vld, e_slot, e_pulse, e_busy, e_done};
  endfunction

  function automatic logic [31:0] mk_ctrl(input bit run, input bit one, input int last, input int dwell);
    logic [31:0] c;
    c = '0;
    c[0] = run;
    c[1] = one;
    c[3:2] = last[1:0];
    c[31:16] = dwell[15:0];
    return c;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_armed = 0; m_run_prev = 0; m_one = 0;
    m_frames = 0; m_last = 0; m_dwell = 1;
    e_sel = '0; e_slot = '0; e_vld = 0; e_pulse = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic model_edge(input logic run, input logic fs, input logic [31:0] ctrl,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3);
    bit start;
    int j, s;
    logic [31:0] bin;
    start = run && !m_run_prev && m_armed;
    e_pulse = 0;
    if (!run) begin
      m_active = 0; m_done = 0; e_vld = 0; e_busy = 0; e_done = 0;
    end else if (m_done) begin
      e_done = 1;
    end else if (m_active) begin
      if (fs) begin
        j = m_frames;
        m_frames++;
        if (m_one && j == (m_last + 1) * m_dwell) begin
          m_active = 0; m_done = 1; e_vld = 0; e_busy = 0; e_done = 1;
        end else if (j % m_dwell == 0) begin
          s = (j / m_dwell) % (m_last + 1);
          bin = (s == 0) ? b0 : (s == 1) ? b1 : (s == 2) ? b2 : b3;
          e_sel = bin[8:0]; e_slot = s[1:0]; e_vld = 1; e_pulse = 1;
        end
      end
    end else if (start) begin
      m_active = 1; m_frames = 0;
      m_last = int'(ctrl[3:2]); m_one = ctrl[1];
      m_dwell = (ctrl[31:16] == 0) ? 1 : int'(ctrl[31:16]);
      e_busy = 1;
    end
    if (!run) m_armed = 1;
    m_run_prev = run;
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick();
    logic r, f;
    logic [31:0] c, b0, b1, b2, b3;
    r = ctrl_reg[0]; f = frame_sync; c = ctrl_reg;
    b0 = ch_bin0; b1 = ch_bin1; b2 = ch_bin2; b3 = ch_bin3;
    @(posedge user_clk);
    if (!user_rst_n) model_reset();
    else model_edge(r, f, c, b0, b1, b2, b3);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge user_clk);
    #1;
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_state got %h want %h", obs(), 15'h0);
    end
    user_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_basic_cycle();
    int pulses;
    pulses = 0;
    ch_bin0 = 5; ch_bin1 = 17; ch_bin2 = 300; ch_bin3 = 511;
    ctrl_reg = mk_ctrl(0, 0, 3, 2);
    tick();
    ctrl_reg = mk_ctrl(1, 0, 3, 2);
    for (int i = 0; i < 75; i++) begin
      frame_sync = (i % 8 == 3);
      tick();
      frame_sync = 1'b0;
      if (switch_pulse) pulses++;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL basic cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    vectors++;
    if (pulses !== 5 || ch_sel !== 9'd5) begin
      miscompares++;
      $display("FAIL basic_summary got pulses=%0d sel=%0d want pulses=5 sel=5", pulses, ch_sel);
    end
    ctrl_reg = mk_ctrl(0, 0, 3, 2);
    tick();
  endtask

  task automatic test_one_shot();
    ctrl_reg = mk_ctrl(0, 1, 1, 1);
    tick();
    ctrl_reg = mk_ctrl(1, 1, 1, 1);
    for (int i = 0; i < 14; i++) begin
      frame_sync = (i % 4 == 2);
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL one_shot cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({done, ch_sel_valid, busy, ch_sel} !== {3'b100, 9'd17}) begin
      miscompares++;
      $display("FAIL one_shot_done got d=%b v=%b b=%b sel=%0d want d=1 v=0 b=0 sel=17",
               done, ch_sel_valid, busy, ch_sel);
    end
    ctrl_reg = mk_ctrl(0, 1, 1, 1);
    tick();
    vectors++;
    if (done !== 1'b0 || obs() !== expv()) begin
      miscompares++;
      $display("FAIL one_shot_clear got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_dwell_zero_same_cycle();
    ctrl_reg = mk_ctrl(0, 0, 3, 0);
    tick();
    ctrl_reg = mk_ctrl(1, 0, 3, 0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    vectors++;
    if ({busy, ch_sel_valid, switch_pulse} !== 3'b100) begin
      miscompares++;
      $display("FAIL same_cycle_start got b=%b v=%b p=%b want b=1 v=0 p=0",
               busy, ch_sel_valid, switch_pulse);
    end
    for (int i = 0; i < 18; i++) begin
      frame_sync = (i % 3 == 1);
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL dwell_zero cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    ctrl_reg = mk_ctrl(0, 0, 3, 0);
    tick();
  endtask

  task automatic test_retune_stop();
    ch_bin0 = 5; ch_bin1 = 17;
    ctrl_reg = mk_ctrl(0, 0, 1, 1);
    tick();
    ctrl_reg = mk_ctrl(1, 0, 1, 1);
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    ch_bin1 = 42;
    tick();
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    vectors++;
    if ({ch_sel, slot_idx, switch_pulse} !== {9'd42, 2'd1, 1'b1} || obs() !== expv()) begin
      miscompares++;
      $display("FAIL retune got sel=%0d slot=%0d p=%b want sel=42 slot=1 p=1",
               ch_sel, slot_idx, switch_pulse);
    end
    tick();
    ctrl_reg = mk_ctrl(0, 0, 1, 1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    vectors++;
    if ({ch_sel_valid, busy, switch_pulse, ch_sel} !== {3'b000, 9'd42} || obs() !== expv()) begin
      miscompares++;
      $display("FAIL stop_wins got v=%b b=%b p=%b sel=%0d want v=0 b=0 p=0 sel=42",
               ch_sel_valid, busy, switch_pulse, ch_sel);
    end
  endtask

  task automatic test_async_reset();
    ch_bin0 = 5; ch_bin1 = 17; ch_bin2 = 300; ch_bin3 = 511;
    ctrl_reg = mk_ctrl(1, 0, 3, 2);
    tick();
    for (int i = 0; i < 6; i++) begin
      frame_sync = (i % 2 == 0);
      tick();
      frame_sync = 1'b0;
    end
    vectors++;
    if (busy !== 1'b1 || obs() !== expv()) begin
      miscompares++;
      $display("FAIL pre_reset got %h want %h", obs(), expv());
    end
    #2;
    user_rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL async_reset got %h want %h", obs(), 15'h0);
    end
    tick();
    user_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_sync = (i % 2 == 0);
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (busy !== 1'b0 || obs() !== expv()) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    ctrl_reg = mk_ctrl(0, 0, 3, 2);
    tick();
    ctrl_reg = mk_ctrl(1, 0, 3, 2);
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    vectors++;
    if ({ch_sel, ch_sel_valid, busy} !== {9'd5, 2'b11} || obs() !== expv()) begin
      miscompares++;
      $display("FAIL restart got %h want %h", obs(), expv());
    end
    ctrl_reg = mk_ctrl(0, 0, 3, 2);
    tick();
  endtask

  task automatic test_random();
    bit run;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0)
        ctrl_reg = mk_ctrl(run, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)));
      else
        ctrl_reg[0] = run;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: ch_bin0 = $urandom;
          1: ch_bin1 = $urandom;
          2: ch_bin2 = $urandom;
          default: ch_bin3 = $urandom;
        endcase
      end
      frame_sync = ($urandom_range(0, 3) == 0);
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random cyc%0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
    test_one_shot();
    test_dwell_zero_same_cycle();
    test_retune_stop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
